// File: rtl/arb_pkg.sv
// Shared types for the core memory arbiter: FSM states, source ids and the request payload.
package arb_pkg;

   localparam int unsigned ARB_ADDR_W = 32;
   localparam int unsigned ARB_DATA_W = 32;
   localparam int unsigned ARB_STRB_W = ARB_DATA_W / 8;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_FETCH = 1'b0,
      SRC_MEM   = 1'b1
   } src_t;

   typedef struct packed {
      logic                  mode;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
      logic [ARB_STRB_W-1:0] wstrb;
   } req_t;

endpackage

// File: rtl/arb_req_slot.sv
// One-deep pending request slot per source; a set pulse while already pending is
// dropped and flagged, except when it coincides with the clear (set wins).
module arb_req_slot
   import arb_pkg::*;
(
   input  logic clk,
   input  logic i_rstn,
   input  logic i_set,
   input  logic i_clear,
   input  req_t i_req,
   output logic o_pending,
   output req_t o_req,
   output logic o_err_c
);

   logic r_pending;
   req_t r_req;
   logic w_accept;

   assign w_accept = i_set & (~r_pending | i_clear);
   assign o_err_c  = i_set & r_pending & ~i_clear;

   always_ff @(posedge clk) begin
      if (!i_rstn) begin
         r_pending <= 1'b0;
         r_req     <= '0;
      end else if (w_accept) begin
         r_pending <= 1'b1;
         r_req     <= i_req;
      end else if (i_clear) begin
         r_pending <= 1'b0;
      end
   end

   assign o_pending = r_pending;
   assign o_req     = r_req;

endmodule

// File: rtl/core_mem_arbiter.sv
// Merges fetch and data requests onto one external memory bus, one transaction in flight.
// ARB_ROUND_ROBIN_EN: alternate grants on ties instead of fixed mem-over-fetch priority.
module core_mem_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ARB_ADDR_W,
   parameter int unsigned DATA_W = ARB_DATA_W
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                fetch_request_enable,
   input  logic                freq_mode,
   input  logic [ADDR_W-1:0]   freq_addr,
   input  logic [DATA_W-1:0]   freq_wdata,
   input  logic [DATA_W/8-1:0] freq_wstrb,
   output logic                fetch_response_enable,
   output logic [DATA_W-1:0]   fresp_data,
   input  logic                mem_request_enable,
   input  logic                mreq_mode,
   input  logic [ADDR_W-1:0]   mreq_addr,
   input  logic [DATA_W-1:0]   mreq_wdata,
   input  logic [DATA_W/8-1:0] mreq_wstrb,
   output logic                mem_response_enable,
   output logic [DATA_W-1:0]   mresp_data,
   output logic                ext_req_valid,
   input  logic                ext_req_ready,
   output logic                ext_req_mode,
   output logic [ADDR_W-1:0]   ext_req_addr,
   output logic [DATA_W-1:0]   ext_req_wdata,
   output logic [DATA_W/8-1:0] ext_req_wstrb,
   input  logic                ext_resp_valid,
   input  logic [DATA_W-1:0]   ext_resp_data,
   output logic                arb_error
);

   req_t       w_fetch_in, w_mem_in, w_fetch_req, w_mem_req;
   logic       w_fetch_pend, w_mem_pend, w_fetch_err, w_mem_err;
   logic       w_clr_fetch, w_clr_mem;
   src_t       w_pick;

   arb_state_t r_state, w_state_nxt;
   src_t       r_owner, w_owner_nxt;
   logic       w_load, w_valid_nxt, w_fresp_nxt, w_mresp_nxt, w_spurious;

   logic              r_ext_req_valid;
   req_t              r_ext_req;
   logic              r_fresp_en, r_mresp_en, r_arb_error;
   logic [DATA_W-1:0] r_fresp_data, r_mresp_data;

   assign w_fetch_in = '{mode: freq_mode, addr: freq_addr, wdata: freq_wdata, wstrb: freq_wstrb};
   assign w_mem_in   = '{mode: mreq_mode, addr: mreq_addr, wdata: mreq_wdata, wstrb: mreq_wstrb};

   arb_req_slot u_fetch_slot (
      .clk       (clk),
      .i_rstn    (rstn),
      .i_set     (fetch_request_enable),
      .i_clear   (w_clr_fetch),
      .i_req     (w_fetch_in),
      .o_pending (w_fetch_pend),
      .o_req     (w_fetch_req),
      .o_err_c   (w_fetch_err)
   );

   arb_req_slot u_mem_slot (
      .clk       (clk),
      .i_rstn    (rstn),
      .i_set     (mem_request_enable),
      .i_clear   (w_clr_mem),
      .i_req     (w_mem_in),
      .o_pending (w_mem_pend),
      .o_req     (w_mem_req),
      .o_err_c   (w_mem_err)
   );

`ifdef ARB_ROUND_ROBIN_EN
   src_t r_last_grant;

   // Only tie-break decisions move the round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_last_grant <= SRC_FETCH;
      end else if (w_load && w_fetch_pend && w_mem_pend) begin
         r_last_grant <= w_pick;
      end
   end

   always_comb begin
      w_pick = SRC_FETCH;
      if (w_fetch_pend && w_mem_pend) begin
         w_pick = (r_last_grant == SRC_MEM) ? SRC_FETCH : SRC_MEM;
      end else if (w_mem_pend) begin
         w_pick = SRC_MEM;
      end
   end
`else
   always_comb begin
      w_pick = w_mem_pend ? SRC_MEM : SRC_FETCH;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_owner <= SRC_FETCH;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_load      = 1'b0;
      w_valid_nxt = r_ext_req_valid;
      w_fresp_nxt = 1'b0;
      w_mresp_nxt = 1'b0;
      w_clr_fetch = 1'b0;
      w_clr_mem   = 1'b0;
      w_spurious  = 1'b0;
      case (r_state)
         IDLE: begin
            w_spurious = ext_resp_valid;
            if (w_fetch_pend || w_mem_pend) begin
               w_load      = 1'b1;
               w_owner_nxt = w_pick;
               w_valid_nxt = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            w_spurious = ext_resp_valid;
            if (ext_req_ready) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (ext_resp_valid) begin
               w_state_nxt = IDLE;
               if (r_owner == SRC_MEM) begin
                  w_mresp_nxt = 1'b1;
                  w_clr_mem   = 1'b1;
               end else begin
                  w_fresp_nxt = 1'b1;
                  w_clr_fetch = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Registered downstream request, response pulses/data and sticky error.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_ext_req_valid <= 1'b0;
         r_ext_req       <= '0;
         r_fresp_en      <= 1'b0;
         r_mresp_en      <= 1'b0;
         r_fresp_data    <= '0;
         r_mresp_data    <= '0;
         r_arb_error     <= 1'b0;
      end else begin
         r_ext_req_valid <= w_valid_nxt;
         if (w_load) begin
            r_ext_req <= (w_pick == SRC_MEM) ? w_mem_req : w_fetch_req;
         end
         r_fresp_en <= w_fresp_nxt;
         r_mresp_en <= w_mresp_nxt;
         if (w_fresp_nxt) begin
            r_fresp_data <= ext_resp_data;
         end
         if (w_mresp_nxt) begin
            r_mresp_data <= ext_resp_data;
         end
         if (w_spurious || w_fetch_err || w_mem_err) begin
            r_arb_error <= 1'b1;
         end
      end
   end

   assign ext_req_valid         = r_ext_req_valid;
   assign ext_req_mode          = r_ext_req.mode;
   assign ext_req_addr          = r_ext_req.addr;
   assign ext_req_wdata         = r_ext_req.wdata;
   assign ext_req_wstrb         = r_ext_req.wstrb;
   assign fetch_response_enable = r_fresp_en;
   assign mem_response_enable   = r_mresp_en;
   assign fresp_data            = r_fresp_data;
   assign mresp_data            = r_mresp_data;
   assign arb_error             = r_arb_error;

endmodule
